// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: load funct3 encodings and default register-file geometry.
package riscv_pkg;

  localparam int unsigned ADDRSIZE_DEF = 5;
  localparam int unsigned WORDSIZE_DEF = 64;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

endpackage

// File: rtl/load_extend.sv
// Sign/zero-extends a right-aligned load word according to its funct3 load type.
module load_extend
  import riscv_pkg::*;
#(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF
) (
  input  logic [WORDSIZE-1:0] mem_data,
  input  logic [2:0]          mem_funct3,
  output logic [WORDSIZE-1:0] ext_data_c
);

  always_comb begin
    ext_data_c = mem_data;
    case (mem_funct3)
      F3_LB:   ext_data_c = {{(WORDSIZE-8){mem_data[7]}},   mem_data[7:0]};
      F3_LH:   ext_data_c = {{(WORDSIZE-16){mem_data[15]}}, mem_data[15:0]};
      F3_LW:   ext_data_c = {{(WORDSIZE-32){mem_data[31]}}, mem_data[31:0]};
      F3_LD:   ext_data_c = mem_data;
      F3_LBU:  ext_data_c = {{(WORDSIZE-8){1'b0}},  mem_data[7:0]};
      F3_LHU:  ext_data_c = {{(WORDSIZE-16){1'b0}}, mem_data[15:0]};
      F3_LWU:  ext_data_c = {{(WORDSIZE-32){1'b0}}, mem_data[31:0]};
      default: ext_data_c = mem_data;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: arbitrates load and ALU results onto one registered write port,
// buffering one ALU result when a load wins. Optional counters under `WB_STATS_EN.
module regfile_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned WORDSIZE = WORDSIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDRSIZE-1:0] alu_rd,
  input  logic [WORDSIZE-1:0] alu_data,
  input  logic                mem_valid,
  input  logic [ADDRSIZE-1:0] mem_rd,
  input  logic [WORDSIZE-1:0] mem_data,
  input  logic [2:0]          mem_funct3,
  output logic                regwr,
  output logic [ADDRSIZE-1:0] rd,
  output logic [WORDSIZE-1:0] rddata
`ifdef WB_STATS_EN
  ,
  output logic [31:0]         wb_count,
  output logic [31:0]         stall_count
`endif
);

  logic                regwr_q, regwr_d;
  logic [ADDRSIZE-1:0] rd_q, rd_d;
  logic [WORDSIZE-1:0] rddata_q, rddata_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDRSIZE-1:0] pend_rd_q, pend_rd_d;
  logic [WORDSIZE-1:0] pend_data_q, pend_data_d;

  logic [WORDSIZE-1:0] mem_ext_c;
  logic                mem_win_c;
  logic                alu_take_c;

  load_extend #(.WORDSIZE(WORDSIZE)) u_load_extend (
    .mem_data   (mem_data),
    .mem_funct3 (mem_funct3),
    .ext_data_c (mem_ext_c)
  );

  assign alu_ready  = !pend_valid_q;
  // Results targeting x0 are dropped at acceptance and never compete for the slot.
  assign mem_win_c  = mem_valid && (mem_rd != '0);
  assign alu_take_c = alu_valid && !pend_valid_q && (alu_rd != '0);

  always_comb begin
    regwr_d      = 1'b0;
    rd_d         = rd_q;
    rddata_d     = rddata_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_data_d  = pend_data_q;
    if (mem_win_c) begin
      regwr_d  = 1'b1;
      rd_d     = mem_rd;
      rddata_d = mem_ext_c;
      if (alu_take_c) begin
        pend_valid_d = 1'b1;
        pend_rd_d    = alu_rd;
        pend_data_d  = alu_data;
      end
    end else if (pend_valid_q) begin
      regwr_d      = 1'b1;
      rd_d         = pend_rd_q;
      rddata_d     = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (alu_take_c) begin
      regwr_d  = 1'b1;
      rd_d     = alu_rd;
      rddata_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwr_q      <= 1'b0;
      rd_q         <= '0;
      rddata_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_data_q  <= '0;
    end else begin
      regwr_q      <= regwr_d;
      rd_q         <= rd_d;
      rddata_q     <= rddata_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
    end
  end

  assign regwr  = regwr_q;
  assign rd     = rd_q;
  assign rddata = rddata_q;

`ifdef WB_STATS_EN
  logic [31:0] wb_count_q, wb_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    wb_count_d    = wb_count_q + 32'(regwr_q);
    stall_count_d = stall_count_q + 32'(alu_valid && !alu_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wb_count_q    <= wb_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wb_count    = wb_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (counter checks when WB_STATS_EN is defined).
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_funct3;
  logic        regwr;
  logic [4:0]  rd;
  logic [63:0] rddata;
`ifdef WB_STATS_EN
  logic [31:0] wb_count;
  logic [31:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.ADDRSIZE(5), .WORDSIZE(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_funct3 (mem_funct3),
    .regwr      (regwr),
    .rd         (rd),
    .rddata     (rddata)
`ifdef WB_STATS_EN
    ,
    .wb_count   (wb_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] exp_rd, input logic [63:0] exp_data);
    chk({tag, ".regwr"}, 64'(regwr), 64'd1);
    chk({tag, ".rd"}, 64'(rd), 64'(exp_rd));
    chk({tag, ".data"}, rddata, exp_data);
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    mem_valid  = 1'b0;
    mem_rd     = '0;
    mem_data   = '0;
    mem_funct3 = '0;
  endtask

  logic [63:0] ext_exp [8];

  initial begin
    ext_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ext_exp[1] = 64'hFFFF_FFFF_FFFF_8080;
    ext_exp[2] = 64'hFFFF_FFFF_8000_8080;
    ext_exp[3] = 64'hFFFF_FFFF_8000_8080;
    ext_exp[4] = 64'h0000_0000_0000_0080;
    ext_exp[5] = 64'h0000_0000_0000_8080;
    ext_exp[6] = 64'h0000_0000_8000_8080;
    ext_exp[7] = 64'hFFFF_FFFF_8000_8080;

    // Reset held two cycles with an ALU result offered.
    idle_inputs();
    rst_n     = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    alu_data  = 64'h9;
    tick();
    tick();
    chk("rst.regwr", 64'(regwr), 64'd0);
    chk("rst.rd", 64'(rd), 64'd0);
    chk("rst.rddata", rddata, 64'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();
    chk("rst.ready", 64'(alu_ready), 64'd1);
    chk("rst.nowr", 64'(regwr), 64'd0);

    // Single ALU write, then idle holds rd/rddata.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    idle_inputs();
    chk_wr("alu1", 5'd5, 64'h1234);
    tick();
    chk("alu1.idle", 64'(regwr), 64'd0);
    chk("alu1.hold_rd", 64'(rd), 64'd5);
    chk("alu1.hold_data", rddata, 64'h1234);

    // Same-cycle load and ALU to x3: load first, ALU last.
    mem_valid = 1'b1; mem_rd = 5'd3; mem_funct3 = 3'b000; mem_data = 64'h80;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h7;
    chk("col.ready0", 64'(alu_ready), 64'd1);
    tick();
    idle_inputs();
    chk_wr("col.load", 5'd3, 64'hFFFF_FFFF_FFFF_FF80);
    chk("col.ready1", 64'(alu_ready), 64'd0);
    tick();
    chk_wr("col.alu", 5'd3, 64'h7);
    chk("col.ready2", 64'(alu_ready), 64'd1);
    tick();
    chk("col.idle", 64'(regwr), 64'd0);

    // Back-to-back extension sweep over every funct3.
    for (int i = 0; i < 8; i++) begin
      mem_valid  = 1'b1;
      mem_rd     = 5'(10 + i);
      mem_funct3 = 3'(i);
      mem_data   = 64'hFFFF_FFFF_8000_8080;
      tick();
      chk_wr($sformatf("ext%0d", i), 5'(10 + i), ext_exp[i]);
    end
    idle_inputs();
    tick();

    // Pending x9 drains while a load to x0 is offered; x0 is never written.
    mem_valid = 1'b1; mem_rd = 5'd2; mem_funct3 = 3'b011; mem_data = 64'hAA;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    tick();
    chk_wr("x0.load", 5'd2, 64'hAA);
    alu_valid = 1'b0;
    mem_rd = 5'd0; mem_data = 64'h55;
    tick();
    chk_wr("x0.pend", 5'd9, 64'h99);
    tick();
    chk("x0.memdrop", 64'(regwr), 64'd0);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h77;
    tick();
    idle_inputs();
    chk("x0.aludrop", 64'(regwr), 64'd0);
    chk("x0.ready", 64'(alu_ready), 64'd1);

    // A held ALU result stalls behind the buffer and never overtakes it.
    mem_valid = 1'b1; mem_rd = 5'd1; mem_funct3 = 3'b011; mem_data = 64'h11;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
    tick();
    chk_wr("ord.A", 5'd1, 64'h11);
    chk("ord.A.ready", 64'(alu_ready), 64'd0);
    mem_data = 64'h12;
    alu_rd = 5'd4; alu_data = 64'h44;
    tick();
    chk_wr("ord.B", 5'd1, 64'h12);
    chk("ord.B.ready", 64'(alu_ready), 64'd0);
    mem_valid = 1'b0;
    tick();
    chk_wr("ord.C", 5'd6, 64'h66);
    chk("ord.C.ready", 64'(alu_ready), 64'd1);
    tick();
    idle_inputs();
    chk_wr("ord.D", 5'd4, 64'h44);
`ifdef WB_STATS_EN
    chk("ord.stalls", 64'(stall_count), 64'd2);
`endif
    tick();
    chk("ord.idle", 64'(regwr), 64'd0);

    // Reset while an ALU entry is buffered discards it.
    mem_valid = 1'b1; mem_rd = 5'd1; mem_funct3 = 3'b011; mem_data = 64'h21;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
    tick();
    idle_inputs();
    chk_wr("mrst.load", 5'd1, 64'h21);
    chk("mrst.pend", 64'(alu_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("mrst.regwr", 64'(regwr), 64'd0);
    chk("mrst.rd", 64'(rd), 64'd0);
    chk("mrst.rddata", rddata, 64'd0);
    chk("mrst.ready", 64'(alu_ready), 64'd1);
`ifdef WB_STATS_EN
    chk("mrst.wbcnt", 64'(wb_count), 64'd0);
    chk("mrst.stallcnt", 64'(stall_count), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("mrst.nowr1", 64'(regwr), 64'd0);
    tick();
    chk("mrst.nowr2", 64'(regwr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
